// File: rtl/alu_seq_param.sv
// alu_seq_param: registered W-bit ALU with a valid/ready handshake on both sides.
// Every opcode except DIV completes in one cycle. DIV with a non-zero divisor runs a
// restoring divider for W cycles. z, zero_f and dz_err are registered together and
// held stable in DONE until the sink accepts them.
module alu_seq_param #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     opcode,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] z,
  output logic           zero_f,
  output logic           dz_err
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_DIV  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_GT   = 4'h4;
  localparam logic [3:0] OP_LT   = 4'h5;
  localparam logic [3:0] OP_EQ   = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_NOT  = 4'hC;
  localparam logic [3:0] OP_NAND = 4'hD;
  localparam logic [3:0] OP_NOR  = 4'hE;
  localparam logic [3:0] OP_XNOR = 4'hF;

  // Shift amounts at or beyond these limits flush the operand completely.
  localparam logic [2*W-1:0] SHL_LIM  = (2*W)'(2 * W);
  localparam logic [W-1:0]   SHR_LIM  = W'(W);
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [1:0]     state_q, state_d;
  logic [2*W-1:0] z_q, z_d;
  logic           zero_q, zero_d;
  logic           dz_q, dz_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [2*W-1:0] xe_s, ye_s, res_s;
  logic           dz_s;
  logic           accept_s, start_div_s;
  logic [W:0]     shift_s, diff_s;
  logic           ge_s;
  logic [W-1:0]   step_rem_s, step_quo_s;

  assign in_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_s    = in_valid && in_ready;
  assign start_div_s = (opcode == OP_DIV) && (y != {W{1'b0}});

  assign out_valid = (state_q == ST_DONE);
  assign z         = z_q;
  assign zero_f    = zero_q;
  assign dz_err    = dz_q;

  // Single-cycle result for the opcode presented at the input.
  always_comb begin
    xe_s  = {{W{1'b0}}, x};
    ye_s  = {{W{1'b0}}, y};
    res_s = {(2*W){1'b0}};
    dz_s  = 1'b0;
    case (opcode)
      OP_ADD:  res_s = xe_s + ye_s;
      OP_SUB:  res_s = xe_s - ye_s;
      OP_MUL:  res_s = xe_s * ye_s;
      OP_DIV: begin
        // Only the divide-by-zero case completes here; a real divide uses the iterator.
        if (y == {W{1'b0}}) begin
          res_s = {(2*W){1'b1}};
          dz_s  = 1'b1;
        end else begin
          res_s = {(2*W){1'b0}};
          dz_s  = 1'b0;
        end
      end
      OP_GT:   res_s = {{(2*W-1){1'b0}}, (x > y)};
      OP_LT:   res_s = {{(2*W-1){1'b0}}, (x < y)};
      OP_EQ:   res_s = {{(2*W-1){1'b0}}, (x == y)};
      OP_AND:  res_s = {{W{1'b0}}, x & y};
      OP_OR:   res_s = {{W{1'b0}}, x | y};
      OP_XOR:  res_s = {{W{1'b0}}, x ^ y};
      OP_SHL: begin
        if (ye_s >= SHL_LIM) res_s = {(2*W){1'b0}};
        else                 res_s = xe_s << y;
      end
      OP_SHR: begin
        if (y >= SHR_LIM) res_s = {(2*W){1'b0}};
        else              res_s = {{W{1'b0}}, x >> y};
      end
      OP_NOT:  res_s = {{W{1'b0}}, ~x};
      OP_NAND: res_s = {{W{1'b0}}, ~(x & y)};
      OP_NOR:  res_s = {{W{1'b0}}, ~(x | y)};
      OP_XNOR: res_s = {{W{1'b0}}, ~(x ^ y)};
      default: res_s = {(2*W){1'b0}};
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  // The partial remainder is always below the divisor, so diff_s[W] is a clean borrow.
  always_comb begin
    shift_s    = {rem_q, quo_q[W-1]};
    diff_s     = shift_s - {1'b0, dvs_q};
    ge_s       = ~diff_s[W];
    step_quo_s = {quo_q[W-2:0], ge_s};
    if (ge_s) step_rem_s = diff_s[W-1:0];
    else      step_rem_s = shift_s[W-1:0];
  end

  // Next-state logic for the handshake FSM, result registers and divider datapath.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    zero_d  = zero_q;
    dz_d    = dz_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          if (start_div_s) begin
            state_d = ST_DIV;
            rem_d   = {W{1'b0}};
            quo_d   = x;
            dvs_d   = y;
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = ST_DONE;
            z_d     = res_s;
            zero_d  = (res_s == {(2*W){1'b0}});
            dz_d    = dz_s;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_DIV: begin
        rem_d = step_rem_s;
        quo_d = step_quo_s;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          z_d     = {step_rem_s, step_quo_s};
          zero_d  = ({step_rem_s, step_quo_s} == {(2*W){1'b0}});
          dz_d    = 1'b0;
        end else begin
          state_d = ST_DIV;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State update; reset abandons any divide in flight and clears the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      z_q     <= {(2*W){1'b0}};
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
      rem_q   <= {W{1'b0}};
      quo_q   <= {W{1'b0}};
      dvs_q   <= {W{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      dz_q    <= dz_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
